// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle control FSM for the LEGv8 subset (R-format, LDUR, STUR, CBZ).
// Sequences a shared-memory, single-ALU datapath and counts retired instructions.
module legv8_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      Op,
  input  logic             Zero,
  input  logic             mem_ack,
  output logic             PCWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Reg2Loc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSrc,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ILLEGAL = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             is_r, is_cbz, is_ldur, is_stur;

  // Opcode class decode from the IR opcode field
  always_comb begin
    is_r    = 1'b0;
    is_cbz  = 1'b0;
    is_ldur = 1'b0;
    is_stur = 1'b0;
    casez (Op)
      11'b1?0_0101_1000,
      11'b10?_0101_0000: is_r    = 1'b1;
      11'b101_1010_0???: is_cbz  = 1'b1;
      11'b111_1100_0010: is_ldur = 1'b1;
      11'b111_1100_0000: is_stur = 1'b1;
      default:           ;
    endcase
  end

  // Next-state, counter and Moore/Mealy control decode
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    retire    = 1'b0;
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    Reg2Loc   = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ack;
        IRWrite = mem_ack;
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Reg2Loc = is_cbz | is_stur;
        if (is_r)                  state_d = S_EXEC;
        else if (is_ldur | is_stur) state_d = S_MEMADR;
        else if (is_cbz)           state_d = S_BRANCH;
        else begin
          state_d   = S_ILLEGAL;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Reg2Loc = is_stur;
        if (is_ldur)      state_d = S_MEMRD;
        else if (is_stur) state_d = S_MEMWR;
        else begin
          // Opcode changed under us after decode: treat as unsupported
          state_d   = S_ILLEGAL;
          illegal_d = 1'b1;
        end
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ack) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ack) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        Reg2Loc = 1'b1;
        PCSrc   = 1'b1;
        PCWrite = Zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase

    if (retire) cnt_d = cnt_q + CNT_W'(1);

    // No strobe or write enable may leak out while reset is held
    if (!reset) begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      Reg2Loc  = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSrc    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed, table-driven bench for legv8_multicycle_ctrl; a narrow counter
// makes wrap-around reachable in a short run.
module tb_legv8_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_BAD  = 11'b00000000000;

  // {PCWrite,IorD,IRWrite,MemRead,MemWrite,MemtoReg,RegWrite,Reg2Loc,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
  localparam logic [13:0] C_ZERO      = 14'b0_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [13:0] C_FETCH_ACK = 14'b1_0_1_1_0_0_0_0_0_01_00_0;
  localparam logic [13:0] C_FETCH_WT  = 14'b0_0_0_1_0_0_0_0_0_01_00_0;
  localparam logic [13:0] C_DEC       = 14'b0_0_0_0_0_0_0_0_0_11_00_0;
  localparam logic [13:0] C_DEC_R2L   = 14'b0_0_0_0_0_0_0_1_0_11_00_0;
  localparam logic [13:0] C_MADR_L    = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [13:0] C_MADR_S    = 14'b0_0_0_0_0_0_0_1_1_10_00_0;
  localparam logic [13:0] C_MEMRD     = 14'b0_1_0_1_0_0_0_0_0_00_00_0;
  localparam logic [13:0] C_MEMWB     = 14'b0_0_0_0_0_1_1_0_0_00_00_0;
  localparam logic [13:0] C_MEMWR     = 14'b0_1_0_0_1_0_0_1_0_00_00_0;
  localparam logic [13:0] C_EXEC      = 14'b0_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [13:0] C_RWB       = 14'b0_0_0_0_0_0_1_0_0_00_00_0;
  localparam logic [13:0] C_BR_T      = 14'b1_0_0_0_0_0_0_1_1_00_01_1;
  localparam logic [13:0] C_BR_N      = 14'b0_0_0_0_0_0_0_1_1_00_01_1;

  logic             clk = 1'b0;
  logic             reset;
  logic [10:0]      Op;
  logic             Zero;
  logic             mem_ack;
  logic             PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg;
  logic             RegWrite, Reg2Loc, ALUSrcA, PCSrc, illegal;
  logic [1:0]       ALUSrcB, ALUOp;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic [13:0]      ctl;

  assign ctl = {PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
                RegWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, PCSrc};

  legv8_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ack(mem_ack),
    .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .state(state), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [10:0] op;
    logic        zero;
    logic        ack;
    logic [3:0]  st;
    logic [13:0] ctl;
    logic [3:0]  cnt;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input logic rst_n, input logic [10:0] op, input logic zero,
                     input logic ack, input logic [3:0] st, input logic [13:0] c,
                     input logic [3:0] cnt, input logic ill);
    vec_t v;
    v.rst_n = rst_n; v.op = op; v.zero = zero; v.ack = ack;
    v.st = st; v.ctl = c; v.cnt = cnt; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rst_n, input logic [10:0] op,
                       input logic zero, input logic ack);
    reset = rst_n; Op = op; Zero = zero; mem_ack = ack;
    #1;
  endtask

  initial begin
    // Reset and release
    add(1'b0, OP_BAD, 1'b0, 1'b1, 4'd0, C_ZERO, 4'd0, 1'b0);
    add(1'b0, OP_BAD, 1'b0, 1'b1, 4'd0, C_ZERO, 4'd0, 1'b0);
    // ADD
    add(1'b1, OP_ADD, 1'b0, 1'b1, 4'd0, C_FETCH_ACK, 4'd0, 1'b0);
    add(1'b1, OP_ADD, 1'b0, 1'b1, 4'd1, C_DEC,       4'd0, 1'b0);
    add(1'b1, OP_ADD, 1'b0, 1'b1, 4'd6, C_EXEC,      4'd0, 1'b0);
    add(1'b1, OP_ADD, 1'b0, 1'b1, 4'd7, C_RWB,       4'd0, 1'b0);
    // LDUR with two wait cycles in MEMRD
    add(1'b1, OP_LDUR, 1'b0, 1'b1, 4'd0, C_FETCH_ACK, 4'd1, 1'b0);
    add(1'b1, OP_LDUR, 1'b0, 1'b1, 4'd1, C_DEC,       4'd1, 1'b0);
    add(1'b1, OP_LDUR, 1'b0, 1'b1, 4'd2, C_MADR_L,    4'd1, 1'b0);
    add(1'b1, OP_LDUR, 1'b0, 1'b0, 4'd3, C_MEMRD,     4'd1, 1'b0);
    add(1'b1, OP_LDUR, 1'b0, 1'b0, 4'd3, C_MEMRD,     4'd1, 1'b0);
    add(1'b1, OP_LDUR, 1'b0, 1'b1, 4'd3, C_MEMRD,     4'd1, 1'b0);
    add(1'b1, OP_LDUR, 1'b0, 1'b1, 4'd4, C_MEMWB,     4'd1, 1'b0);
    // STUR with a FETCH wait and a MEMWR wait
    add(1'b1, OP_STUR, 1'b0, 1'b0, 4'd0, C_FETCH_WT,  4'd2, 1'b0);
    add(1'b1, OP_STUR, 1'b0, 1'b1, 4'd0, C_FETCH_ACK, 4'd2, 1'b0);
    add(1'b1, OP_STUR, 1'b0, 1'b1, 4'd1, C_DEC_R2L,   4'd2, 1'b0);
    add(1'b1, OP_STUR, 1'b0, 1'b1, 4'd2, C_MADR_S,    4'd2, 1'b0);
    add(1'b1, OP_STUR, 1'b0, 1'b0, 4'd5, C_MEMWR,     4'd2, 1'b0);
    add(1'b1, OP_STUR, 1'b0, 1'b1, 4'd5, C_MEMWR,     4'd2, 1'b0);
    // CBZ taken, then not taken
    add(1'b1, OP_CBZ, 1'b1, 1'b1, 4'd0, C_FETCH_ACK, 4'd3, 1'b0);
    add(1'b1, OP_CBZ, 1'b1, 1'b1, 4'd1, C_DEC_R2L,   4'd3, 1'b0);
    add(1'b1, OP_CBZ, 1'b1, 1'b1, 4'd8, C_BR_T,      4'd3, 1'b0);
    add(1'b1, OP_CBZ, 1'b0, 1'b1, 4'd0, C_FETCH_ACK, 4'd4, 1'b0);
    add(1'b1, OP_CBZ, 1'b0, 1'b1, 4'd1, C_DEC_R2L,   4'd4, 1'b0);
    add(1'b1, OP_CBZ, 1'b0, 1'b1, 4'd8, C_BR_N,      4'd4, 1'b0);
    // AND
    add(1'b1, OP_AND, 1'b0, 1'b1, 4'd0, C_FETCH_ACK, 4'd5, 1'b0);
    add(1'b1, OP_AND, 1'b0, 1'b1, 4'd1, C_DEC,       4'd5, 1'b0);
    add(1'b1, OP_AND, 1'b0, 1'b1, 4'd6, C_EXEC,      4'd5, 1'b0);
    add(1'b1, OP_AND, 1'b0, 1'b1, 4'd7, C_RWB,       4'd5, 1'b0);
    // Illegal opcode: trapped until reset, counter frozen
    add(1'b1, OP_BAD, 1'b0, 1'b1, 4'd0, C_FETCH_ACK, 4'd6, 1'b0);
    add(1'b1, OP_BAD, 1'b0, 1'b1, 4'd1, C_DEC,       4'd6, 1'b0);
    for (int k = 0; k < 10; k++)
      add(1'b1, (k % 2 == 0) ? OP_BAD : OP_ADD, 1'b1, 1'b1, 4'd9, C_ZERO, 4'd6, 1'b1);
    add(1'b0, OP_ADD, 1'b0, 1'b1, 4'd9, C_ZERO,      4'd6, 1'b1);
    add(1'b1, OP_ADD, 1'b0, 1'b0, 4'd0, C_FETCH_WT,  4'd0, 1'b0);

    reset = 1'b0; Op = OP_BAD; Zero = 1'b0; mem_ack = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].op, vecs[i].zero, vecs[i].ack);
      check("state",   i, 32'(state),       32'(vecs[i].st));
      check("ctl",     i, 32'(ctl),         32'(vecs[i].ctl));
      check("count",   i, 32'(instr_count), 32'(vecs[i].cnt));
      check("illegal", i, 32'(illegal),     32'(vecs[i].ill));
      step();
    end

    // Reset in the middle of a STUR access abandons it
    drive(1'b0, OP_STUR, 1'b0, 1'b1);
    step();
    drive(1'b1, OP_STUR, 1'b0, 1'b1);
    step();
    step();
    step();
    drive(1'b1, OP_STUR, 1'b0, 1'b0);
    check("mid_wr_state", 0, 32'(state), 32'd5);
    check("mid_wr_strobe", 0, 32'(MemWrite), 32'd1);
    drive(1'b0, OP_STUR, 1'b0, 1'b1);
    check("mid_wr_rst_ctl", 0, 32'(ctl), 32'(C_ZERO));
    step();
    drive(1'b1, OP_STUR, 1'b0, 1'b0);
    check("mid_wr_after_state", 0, 32'(state), 32'd0);
    check("mid_wr_after_cnt", 0, 32'(instr_count), 32'd0);
    check("mid_wr_after_ctl", 0, 32'(ctl), 32'(C_FETCH_WT));

    // Reset in the middle of an LDUR read
    drive(1'b1, OP_LDUR, 1'b0, 1'b1);
    step();
    step();
    step();
    drive(1'b1, OP_LDUR, 1'b0, 1'b0);
    check("mid_rd_state", 0, 32'(state), 32'd3);
    drive(1'b0, OP_LDUR, 1'b0, 1'b1);
    check("mid_rd_rst_ctl", 0, 32'(ctl), 32'(C_ZERO));
    step();
    drive(1'b1, OP_CBZ, 1'b0, 1'b1);
    check("mid_rd_after_state", 0, 32'(state), 32'd0);
    check("mid_rd_after_cnt", 0, 32'(instr_count), 32'd0);

    // Counter wraps modulo 2^CNT_W
    for (int n = 0; n < 15; n++) begin
      drive(1'b1, OP_CBZ, n[0], 1'b1);
      step();
      step();
      step();
    end
    drive(1'b1, OP_CBZ, 1'b0, 1'b1);
    check("wrap_pre_cnt", 0, 32'(instr_count), 32'd15);
    check("wrap_pre_state", 0, 32'(state), 32'd0);
    step();
    step();
    check("wrap_br_state", 0, 32'(state), 32'd8);
    step();
    #1;
    check("wrap_cnt", 0, 32'(instr_count), 32'd0);
    check("wrap_state", 0, 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/legv8_multicycle_ctrl.md
# legv8_multicycle_ctrl

Multi-cycle control FSM for the LEGv8 core. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps for the ADD/SUB/AND/ORR, LDUR, STUR and CBZ subset. It handles the memory handshake, gates the PC and IR writes, and counts retired instructions. It sits beside the datapath and takes the opcode from the datapath's instruction register.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- Op  in  11  instr[31:21] from the datapath IR.
- Zero  in  1  ALU zero flag.
- mem_ack  in  1  memory completes the current MemRead/MemWrite this cycle.
- PCWrite  out  1  load PC.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load the instruction register.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemtoReg  out  1  writeback select: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write enable.
- Reg2Loc  out  1  read-register-2 select: 1 = Rt field.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended D-immediate, 11 = branch offset << 2.
- ALUOp  out  2  00 = add, 01 = pass B / compare zero, 10 = decode funct.
- PCSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- state  out  4  current state encoding, for debug.
- illegal  out  1  sticky: an unsupported opcode was decoded.
- instr_count  out  CNT_W  retired-instruction counter.

## Operation
Opcode classes (casez on Op):
- R: 1?0_0101_1000 or 10?_0101_0000.
- CBZ: 101_1010_0???.
- LDUR: 111_1100_0010.
- STUR: 111_1100_0000.
- Anything else is illegal.

States, with encoding, asserted outputs and transitions. Outputs not listed are 0.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00. PCWrite and IRWrite equal mem_ack. Stay while mem_ack=0; go to DECODE when mem_ack=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (computes the branch target into ALUOut). Reg2Loc=1 for CBZ and STUR. Next state: R→EXEC, LDUR or STUR→MEMADR, CBZ→BRANCH, otherwise→ILLEGAL.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00, Reg2Loc=1 for STUR. Next: LDUR→MEMRD, STUR→MEMWR.
- MEMRD (3): MemRead=1, IorD=1. Wait for mem_ack, then go to MEMWB.
- MEMWB (4): RegWrite=1, MemtoReg=1. Go to FETCH.
- MEMWR (5): MemWrite=1, IorD=1, Reg2Loc=1. Wait for mem_ack, then go to FETCH.
- EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
- RWB (7): RegWrite=1, MemtoReg=0. Go to FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, PCSrc=1, PCWrite=Zero. Go to FETCH.
- ILLEGAL (9): all strobes 0 and illegal=1. Stay here until reset.

Rules:
- Op is only sampled in DECODE and MEMADR. Op is don't-care in every other state.
- instr_count increments by 1 on the edge that leaves MEMWB, MEMWR (on mem_ack), RWB or BRANCH.
- instr_count wraps modulo 2^CNT_W. No saturation.
- A taken or untaken branch counts as retired.
- An illegal instruction is not counted.
- Encodings 10–15 are unreachable. If ever entered, the next state is FETCH.

## Timing
- Reset: when reset=0 at a rising edge, the next state is FETCH, illegal=0 and instr_count=0.
- While reset=0, every control output is forced to 0 combinationally. No memory strobe or write enable is seen during reset.
- Reset asserted mid-MEMWR or MEMRD abandons the access. The counter does not increment.
- Outputs are Moore decodes of state, except:
  - PCWrite and IRWrite in FETCH, which follow mem_ack.
  - PCWrite in BRANCH, which follows Zero.
- Latency with mem_ack=1 on the first strobe cycle:
  - R-format: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ: 3 cycles.
- Each cycle mem_ack is held low in FETCH, MEMRD or MEMWR adds 1 cycle.
- mem_ack outside FETCH, MEMRD and MEMWR is ignored.
- The first cycle after reset release is FETCH with MemRead=1.

## Test plan
- Reset held low 3 cycles with mem_ack=1 → all strobes 0, state=0, instr_count=0; after release, MemRead=1 in the first cycle.
- ADD, Op=11'b10001011000, mem_ack=1 → states 0,1,6,7,0; RegWrite=1 only in RWB with ALUOp=10; instr_count 0→1.
- LDUR, Op=11'b11111000010, mem_ack low 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; MemRead+IorD=1 for 3 cycles; RegWrite+MemtoReg=1 in MEMWB.
- STUR, Op=11'b11111000000 → MemWrite=1, Reg2Loc=1 in MEMWR; RegWrite never 1; count +1.
- CBZ, Op=11'b10110100xxx: with Zero=1 → PCWrite=1, PCSrc=1 in BRANCH; with Zero=0 → PCWrite=0; count +1 in both cases.
- Op=11'b0 → DECODE goes to ILLEGAL; illegal=1 held for 10 cycles with no strobes and the counter frozen; reset=0 for one edge → FETCH, illegal=0.
